// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-attached RAM controller: command opcodes and
// the transmit-side state encoding.
package spi_ram_pkg;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } opcode_e;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_HOLD = 1'b1
    } tx_state_e;

endpackage

// File: rtl/spi_ram_array.sv
// MEM_DEPTH x 8 single-port RAM with a registered read port that holds its
// value between reads and clears on reset (contents themselves are not reset).
module spi_ram_array #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata
);

    logic [7:0] mem [MEM_DEPTH];
    logic [7:0] rdata_d, rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder between an SPI slave and a single-port RAM: address latching,
// range/protocol checking, optional burst auto-increment and read-data hold.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int AUTO_INC  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       proto_err
);

    logic [ADDR_SIZE-1:0] wr_addr_d, wr_addr_q;
    logic [ADDR_SIZE-1:0] rd_addr_d, rd_addr_q;
    logic                 wa_valid_d, wa_valid_q;
    logic                 ra_valid_d, ra_valid_q;
    logic                 proto_err_d, proto_err_q;
    tx_state_e            state_d, state_q;

    logic                 mem_we, mem_re;
    logic [ADDR_SIZE-1:0] mem_addr;
    opcode_e              op;
    logic                 addr_ok;

    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        if (a == ADDR_SIZE'(MEM_DEPTH - 1)) begin
            return '0;
        end
        return a + 1'b1;
    endfunction

    assign op = opcode_e'(din[9:8]);
    // Full payload byte is compared so stray bits above ADDR_SIZE count as out of range.
    assign addr_ok = ({1'b0, din[7:0]} < 9'(MEM_DEPTH));

    always_comb begin
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        wa_valid_d  = wa_valid_q;
        ra_valid_d  = ra_valid_q;
        state_d     = state_q;
        proto_err_d = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_addr    = wr_addr_q;
        if (rx_valid && !rst) begin
            state_d = TX_IDLE;
            unique case (op)
                OP_WR_ADDR: begin
                    if (addr_ok) begin
                        wr_addr_d  = din[ADDR_SIZE-1:0];
                        wa_valid_d = 1'b1;
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end
                OP_WR_DATA: begin
                    if (wa_valid_q) begin
                        mem_we = 1'b1;
                        if (AUTO_INC != 0) begin
                            wr_addr_d = next_addr(wr_addr_q);
                        end
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end
                OP_RD_ADDR: begin
                    if (addr_ok) begin
                        rd_addr_d  = din[ADDR_SIZE-1:0];
                        ra_valid_d = 1'b1;
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end
                OP_RD_DATA: begin
                    if (ra_valid_q) begin
                        mem_re   = 1'b1;
                        mem_addr = rd_addr_q;
                        state_d  = TX_HOLD;
                        if (AUTO_INC != 0) begin
                            rd_addr_d = next_addr(rd_addr_q);
                        end
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            wa_valid_q  <= 1'b0;
            ra_valid_q  <= 1'b0;
            proto_err_q <= 1'b0;
            state_q     <= TX_IDLE;
        end else begin
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            wa_valid_q  <= wa_valid_d;
            ra_valid_q  <= ra_valid_d;
            proto_err_q <= proto_err_d;
            state_q     <= state_d;
        end
    end

    // The array's registered read port doubles as the dout hold register.
    spi_ram_array #(
        .MEM_DEPTH(MEM_DEPTH),
        .ADDR_SIZE(ADDR_SIZE)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (mem_we),
        .re   (mem_re),
        .addr (mem_addr),
        .wdata(din[7:0]),
        .rdata(dout)
    );

    assign tx_valid  = (state_q == TX_HOLD);
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Randomised and directed bench: three controller configurations driven in
// lock-step and compared against a command-level reference model.
module tb_spi_ram_ctrl;

    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [9:0] din;
    logic [7:0] dout_w  [NDUT];
    logic       tx_w    [NDUT];
    logic       perr_w  [NDUT];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        spi_ram_ctrl #(
            .MEM_DEPTH((g == 1) ? 200 : 256),
            .ADDR_SIZE(8),
            .AUTO_INC ((g == 0) ? 0 : 1)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .din      (din),
            .rx_valid (rx_valid),
            .dout     (dout_w[g]),
            .tx_valid (tx_w[g]),
            .proto_err(perr_w[g])
        );
    end

    // Reference model, one slot per configuration.
    int         m_depth [NDUT] = '{256, 200, 256};
    bit         m_inc   [NDUT] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] m_mem   [NDUT][256];
    int         m_wa    [NDUT];
    int         m_ra    [NDUT];
    bit         m_wav   [NDUT];
    bit         m_rav   [NDUT];
    logic [7:0] m_dout  [NDUT];
    bit         m_tx    [NDUT];
    bit         m_perr  [NDUT];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input int k, input bit r, input bit v, input logic [9:0] w);
        int p;
        p = int'(w[7:0]);
        if (r) begin
            m_wa[k] = 0; m_ra[k] = 0; m_wav[k] = 0; m_rav[k] = 0;
            m_dout[k] = 8'h00; m_tx[k] = 0; m_perr[k] = 0;
            return;
        end
        m_perr[k] = 0;
        if (!v) return;
        m_tx[k] = 0;
        case (w[9:8])
            2'b00: if (p < m_depth[k]) begin m_wa[k] = p; m_wav[k] = 1; end else m_perr[k] = 1;
            2'b10: if (p < m_depth[k]) begin m_ra[k] = p; m_rav[k] = 1; end else m_perr[k] = 1;
            2'b01: begin
                if (m_wav[k]) begin
                    m_mem[k][m_wa[k]] = w[7:0];
                    if (m_inc[k]) m_wa[k] = (m_wa[k] + 1) % m_depth[k];
                end else m_perr[k] = 1;
            end
            default: begin
                if (m_rav[k]) begin
                    m_dout[k] = m_mem[k][m_ra[k]];
                    m_tx[k]   = 1;
                    if (m_inc[k]) m_ra[k] = (m_ra[k] + 1) % m_depth[k];
                end else m_perr[k] = 1;
            end
        endcase
    endtask

    // One clock: drive inputs after a falling edge, compare at the next one.
    task automatic step(input bit r, input bit v, input logic [9:0] w);
        rst = r; rx_valid = v; din = w;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            model_update(k, r, v, w);
            check($sformatf("dut%0d tx_valid", k), {7'b0, tx_w[k]}, {7'b0, m_tx[k]});
            check($sformatf("dut%0d proto_err", k), {7'b0, perr_w[k]}, {7'b0, m_perr[k]});
            check($sformatf("dut%0d dout", k), dout_w[k], m_dout[k]);
        end
    endtask

    task automatic cmd(input logic [9:0] w);
        step(1'b0, 1'b1, w);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom_range(0, 1023));
    endtask

    function automatic logic [7:0] pick_payload();
        case ($urandom_range(0, 7))
            0:       return 8'd0;
            1:       return 8'd199;
            2:       return 8'd200;
            3:       return 8'd255;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        rst = 1'b1; rx_valid = 1'b0; din = '0;
        for (int k = 0; k < NDUT; k++) begin
            for (int a = 0; a < 256; a++) m_mem[k][a] = 8'hxx;
        end
        step(1'b1, 1'b0, 10'h000);
        step(1'b1, 1'b1, 10'h300);

        // Preload every address so all later reads have defined contents.
        for (int i = 0; i < 256; i++) begin
            cmd({2'b00, 8'(i)});
            cmd({2'b01, 8'($urandom_range(0, 255))});
        end

        // Basic write/read and hold until next command.
        step(1'b1, 1'b0, 10'h000);
        cmd(10'h0A5); cmd(10'h13C); cmd(10'h2A5); cmd(10'h300);
        idle(3);
        cmd(10'h000);

        // Data commands before any address.
        step(1'b1, 1'b0, 10'h000);
        cmd(10'h155); idle(1);
        cmd(10'h200); cmd(10'h300); cmd(10'h155);

        // Out-of-range address on the 200-deep instance.
        step(1'b1, 1'b0, 10'h000);
        cmd(10'h0C8); cmd(10'h155); cmd(10'h2C8); cmd(10'h300);

        // Auto-increment wrap at the top of memory.
        step(1'b1, 1'b0, 10'h000);
        cmd(10'h0FF); cmd(10'h1AA); cmd(10'h1BB);
        cmd(10'h2FF); cmd(10'h300); cmd(10'h300);

        // Back-to-back reads, then an address write ends the hold.
        cmd(10'h2C6); cmd(10'h300); cmd(10'h300); cmd(10'h300);
        cmd(10'h000); idle(2);

        // Reset coincident with a read while holding.
        cmd(10'h2A5); cmd(10'h300);
        step(1'b1, 1'b1, 10'h300);
        cmd(10'h300); cmd(10'h2A5); cmd(10'h300); cmd(10'h0A5); cmd(10'h300);

        // Random traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0,
                 {2'($urandom_range(0, 3)), pick_payload()});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
